// File: rtl/cpu_run_controller_pkg.sv
// Shared CPU definitions: run-control state encoding and the NOP the IF stage
// substitutes while the pipeline drains.
package cpu_run_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        STEP  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } run_state_t;

    // add $0,$0,$0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

endpackage

// File: rtl/cpu_run_controller_drain_counter.sv
// Loadable down-counter with a zero flag; sets how long the pipeline drains.
module drain_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_run_controller.sv
// Run-control sequencer for the 5-stage CPU: gates PC/pipeline advance for
// run, pause, single-step and drain. Optional cycle counter: CYCLE_COUNT_EN.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic             pause_req,
    input  logic             step,
    input  logic             halt_req,
    input  logic             wb_valid,
    output logic             pc_en,
    output logic             pipe_en,
    output logic             if_flush,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output run_state_t       dbg_state
);

    localparam int DW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    // The zero flag marks the last drain cycle, so load one less than the length.
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH - 2);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] limit_q;
    logic             drain_load;
    logic             drain_zero;
    logic             start_accept;
    logic             fetch_last;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign fetch_last   = ((fetch_cnt + CNT_W'(1)) == limit_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (limit == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (halt_req || fetch_last) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end else if (pause_req) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (halt_req) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (fetch_last) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end else begin
                    state_d = PAUSE;
                end
            end
            DRAIN: begin
                if (drain_zero) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    drain_counter #(.W(DW)) u_drain (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (state_q == DRAIN),
        .zero     (drain_zero)
    );

    assign pc_en     = (state_q == RUN) || (state_q == STEP);
    assign pipe_en   = pc_en || (state_q == DRAIN);
    assign if_flush  = (state_q == DRAIN);
    assign busy      = pipe_en || (state_q == PAUSE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            limit_q     <= '0;
            fetch_cnt   <= '0;
            retired_cnt <= '0;
        end else if (start_accept) begin
            limit_q     <= limit;
            fetch_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (pc_en) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (wb_valid && pipe_en) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= '0;
        end else if (start_accept) begin
            cycle_q <= '0;
        end else if (busy) begin
            cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run-control sequencer for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB). It gates PC update and pipeline-register advance to start, pause, single-step, halt and drain program execution. It bounds each run to a programmable number of fetched instructions and counts retired instructions. It sits beside the CPU top level and drives the global stall/flush controls that the IF stage and the pipeline registers consume.

## Interface
- `PIPE_DEPTH`, default 5: number of pipeline stages. The drain length is PIPE_DEPTH-1 cycles.
- `CNT_W`, default 32: width of the limit input and of all counters.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `start` input, 1: begins a run. Sampled in IDLE/DONE (begin) and in PAUSE (resume).
- `limit` input, CNT_W: number of instructions to fetch. Latched when `start` is accepted.
- `pause_req` input, 1: freezes the pipeline while in RUN.
- `step` input, 1: advances exactly one cycle while in PAUSE.
- `halt_req` input, 1: stops fetching and drains the pipeline (RUN/PAUSE).
- `wb_valid` input, 1: a non-bubble instruction is in WB this cycle.
- `pc_en` output, 1: PC may update and IF fetches.
- `pipe_en` output, 1: all pipeline registers advance.
- `if_flush` output, 1: IF/ID loads a NOP instead of the fetched word.
- `busy` output, 1: state is RUN, STEP, PAUSE or DRAIN.
- `done` output, 1: state is DONE.
- `fetch_cnt` output, CNT_W: instructions fetched in the current run.
- `retired_cnt` output, CNT_W: instructions retired in the current run.
- `cycle_cnt` output, CNT_W: active cycles in the current run. Present only under `CYCLE_COUNT_EN`.

## Operation
- States: IDLE, RUN, PAUSE, STEP, DRAIN, DONE. Outputs are Moore outputs decoded from the state register.
- IDLE: pc_en=0, pipe_en=0, if_flush=0.
  - `start` with limit≠0 → RUN. Latch `limit`; clear all counters.
  - `start` with limit=0 → DONE.
  - `pause_req`, `step` and `halt_req` are ignored.
- RUN: pc_en=1, pipe_en=1.
  - fetch_cnt increments at each edge.
  - Transition priority: halt_req > fetch limit reached (fetch_cnt+1==limit) > pause_req.
  - halt_req or limit reached → DRAIN. pause_req → PAUSE.
- PAUSE: pc_en=0, pipe_en=0, so all stage contents are held.
  - Priority: halt_req → DRAIN; else start → RUN; else step → STEP.
- STEP: pc_en=1, pipe_en=1 for exactly one cycle. fetch_cnt increments.
  - Next state is DRAIN if fetch_cnt+1==limit, else PAUSE.
- DRAIN: pc_en=0, pipe_en=1, if_flush=1 for exactly PIPE_DEPTH-1 cycles, counted by an internal drain counter. Then → DONE.
- DONE: all enables 0, done=1. Counters hold. `start` re-arms with the same rules as in IDLE.
- retired_cnt increments when wb_valid && pipe_en. It wraps modulo 2^CNT_W.
- fetch_cnt never exceeds the latched limit.

## Timing
- Reset (rst=0, any time, including mid-run): state=IDLE; pc_en, pipe_en, if_flush, busy and done are all 0; all counters are 0. The effect is immediate and independent of clk.
- `start` accepted at edge E0 with limit=N:
  - pc_en is high for the N cycles following E0.
  - DRAIN is entered at edge E(N).
  - done rises after edge E(N+PIPE_DEPTH-1).
- Enable latency is zero: a state change at an edge drives the new enables in the cycle that edge begins.
- Single-cycle request pulses are sufficient. A level held high re-triggers in each state where that input is honoured.

## Configuration
- `CYCLE_COUNT_EN` defined: `cycle_cnt` increments at every edge while busy=1. It is cleared on accepted start and on reset, and holds in DONE. PAUSE cycles are counted.
- `CYCLE_COUNT_EN` undefined: the counter is not built and `cycle_cnt` is tied to 0.

## Structure
- The shared CPU package holds the state enum `run_state_t` and the constant `NOP_INSTR` (32'h00000020, add $0,$0,$0), which the IF stage uses when if_flush=1.
- One sub-module, `drain_counter`: a loadable down-counter with a zero flag, used for the DRAIN length.

## Test plan
- limit=5, start pulse at E0, wb_valid=1 whenever pipe_en=1 → pc_en high for 5 cycles; if_flush high for 4 cycles; done=1 after E9; fetch_cnt=5; retired_cnt=9.
- limit=0, start → DONE on the next cycle; pc_en is never 1; fetch_cnt=0.
- limit=10, pause_req at fetch_cnt=3, then 3 step pulses in separate cycles → fetch_cnt=6; pipe_en is high for exactly 3 isolated cycles during PAUSE; start resumes RUN and the run completes with fetch_cnt=10.
- limit=10, halt_req and pause_req together at fetch_cnt=4 → DRAIN (halt wins); fetch_cnt=4; done after 4 more cycles.
- rst asserted for 1 ns mid-DRAIN → all outputs 0 immediately; state IDLE; a following start with limit=2 runs normally.
- With CYCLE_COUNT_EN, limit=3 plus 2 PAUSE cycles → cycle_cnt=9 (3 RUN + 2 PAUSE + 4 DRAIN).
